// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parameterised register file with per-register pending (scoreboard) bits
//
// Purpose: DEPTH x WIDTH register file with two combinational read ports,
//   one write port and a reserve port that marks a register as pending
//   until it is next written. Optional register-0-is-zero behaviour.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
//   data and pending state onto the read ports (write-through).
// Ports:
//   clock               rising-edge clock for all state
//   reset               asynchronous active-low reset
//   readReg1/readReg2   read addresses
//   readData1/readData2 read data (combinational)
//   readBusy1/readBusy2 pending flag of the addressed register
//   writeReg/writeData  write address and data
//   regWrite            write enable (also clears the pending bit)
//   resv/resvReg        reserve strobe and address (sets the pending bit)
module reg_file_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    readReg1,
  input  logic [AW-1:0]    readReg2,
  output logic [WIDTH-1:0] readData1,
  output logic [WIDTH-1:0] readData2,
  output logic             readBusy1,
  output logic             readBusy2,
  input  logic [AW-1:0]    writeReg,
  input  logic [WIDTH-1:0] writeData,
  input  logic             regWrite,
  input  logic             resv,
  input  logic [AW-1:0]    resvReg
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_next;
  logic             wr_ok;
  logic             rv_ok;

  // Register 0 swallows writes and reserves when hardwired to zero.
  assign wr_ok = regWrite && !((ZERO_REG != 0) && (writeReg == '0));
  assign rv_ok = resv && !((ZERO_REG != 0) && (resvReg == '0));

  // Clear first, then set: a reserve to the register being written wins.
  always_comb begin
    pending_next = pending;
    if (wr_ok) pending_next[writeReg] = 1'b0;
    if (rv_ok) pending_next[resvReg]  = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (wr_ok) regs[writeReg] <= writeData;
      pending <= pending_next;
    end
  end

  always_comb begin
    readData1 = regs[readReg1];
    readBusy1 = pending[readReg1];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (readReg1 == writeReg)) begin
      readData1 = writeData;
      readBusy1 = rv_ok && (resvReg == readReg1);
    end
`endif
    if ((ZERO_REG != 0) && (readReg1 == '0)) begin
      readData1 = '0;
      readBusy1 = 1'b0;
    end
    // Forwarding paths are combinational, so mask them explicitly in reset.
    if (!reset) begin
      readData1 = '0;
      readBusy1 = 1'b0;
    end
  end

  always_comb begin
    readData2 = regs[readReg2];
    readBusy2 = pending[readReg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (readReg2 == writeReg)) begin
      readData2 = writeData;
      readBusy2 = rv_ok && (resvReg == readReg2);
    end
`endif
    if ((ZERO_REG != 0) && (readReg2 == '0)) begin
      readData2 = '0;
      readBusy2 = 1'b0;
    end
    if (!reset) begin
      readData2 = '0;
      readBusy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - scoreboard bench for reg_file_param (default and 8x16 zero-reg builds)
module tb_reg_file_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic [1:0]  a_rr1 = '0, a_rr2 = '0, a_wr = '0, a_rvr = '0;
  logic [31:0] a_wd = '0;
  logic        a_we = 1'b0, a_rv = 1'b0;
  logic [31:0] a_rd1, a_rd2;
  logic        a_rb1, a_rb2;

  // Instance B: WIDTH=8, DEPTH=16, ZERO_REG=1
  logic [3:0]  b_rr1 = '0, b_rr2 = '0, b_wr = '0, b_rvr = '0;
  logic [7:0]  b_wd = '0;
  logic        b_we = 1'b0, b_rv = 1'b0;
  logic [7:0]  b_rd1, b_rd2;
  logic        b_rb1, b_rb2;

  reg_file_param dut_a (
    .clock(clk), .reset(rst_n),
    .readReg1(a_rr1), .readReg2(a_rr2),
    .readData1(a_rd1), .readData2(a_rd2),
    .readBusy1(a_rb1), .readBusy2(a_rb2),
    .writeReg(a_wr), .writeData(a_wd), .regWrite(a_we),
    .resv(a_rv), .resvReg(a_rvr)
  );

  reg_file_param #(.WIDTH(8), .DEPTH(16), .ZERO_REG(1)) dut_b (
    .clock(clk), .reset(rst_n),
    .readReg1(b_rr1), .readReg2(b_rr2),
    .readData1(b_rd1), .readData2(b_rd2),
    .readBusy1(b_rb1), .readBusy2(b_rb2),
    .writeReg(b_wr), .writeData(b_wd), .regWrite(b_we),
    .resv(b_rv), .resvReg(b_rvr)
  );

  typedef struct {
    string       name;
    bit          inst;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  event chk_ev;
  int   tests = 0;
  int   fails = 0;

  // Monitor: drains the expectation queue whenever stimulus posts a sample point.
  logic [31:0] act_d1, act_d2;
  logic        act_b1, act_b2;
  initial begin
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        mon_e = q.pop_front();
        if (mon_e.inst) begin
          act_d1 = {24'b0, b_rd1}; act_d2 = {24'b0, b_rd2};
          act_b1 = b_rb1;          act_b2 = b_rb2;
        end else begin
          act_d1 = a_rd1; act_d2 = a_rd2;
          act_b1 = a_rb1; act_b2 = a_rb2;
        end
        tests++;
        if (act_d1 !== mon_e.d1 || act_d2 !== mon_e.d2 ||
            act_b1 !== mon_e.b1 || act_b2 !== mon_e.b2) begin
          fails++;
          $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b, expected d1=%h d2=%h b1=%b b2=%b",
                   mon_e.name, act_d1, act_d2, act_b1, act_b2,
                   mon_e.d1, mon_e.d2, mon_e.b1, mon_e.b2);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input bit inst,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic b1, input logic b2);
    exp_t e;
    e.name = n; e.inst = inst; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2;
    q.push_back(e);
    ->chk_ev;
    #1;
  endtask

  task automatic a_write(input logic [1:0] r, input logic [31:0] d);
    a_we = 1'b1; a_wr = r; a_wd = d;
    tick();
    a_we = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    a_rr1 = 2'd0; a_rr2 = 2'd3;
    expect_out("reset_a", 0, 32'd0, 32'd0, 1'b0, 1'b0);
    expect_out("reset_b", 1, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Write / read
    a_write(2'd3, 32'd15);
    a_rr1 = 2'd1; a_rr2 = 2'd3;
    expect_out("wr3", 0, 32'd0, 32'd15, 1'b0, 1'b0);
    a_write(2'd1, 32'hDEADBEEF);
    expect_out("wr1", 0, 32'hDEADBEEF, 32'd15, 1'b0, 1'b0);

    // Reserve then write clears
    a_rv = 1'b1; a_rvr = 2'd2;
    tick();
    a_rv = 1'b0;
    a_rr1 = 2'd2; a_rr2 = 2'd1;
    expect_out("resv2", 0, 32'd0, 32'hDEADBEEF, 1'b1, 1'b0);
    a_write(2'd2, 32'd7);
    expect_out("wr2_clears", 0, 32'd7, 32'hDEADBEEF, 1'b0, 1'b0);

    // Collisions
    a_rv = 1'b1; a_rvr = 2'd2;
    a_write(2'd2, 32'd9);
    a_rv = 1'b0;
    expect_out("collide_same", 0, 32'd9, 32'hDEADBEEF, 1'b1, 1'b0);
    a_rv = 1'b1; a_rvr = 2'd1;
    a_write(2'd2, 32'd10);
    a_rv = 1'b0;
    a_rr1 = 2'd1; a_rr2 = 2'd2;
    expect_out("collide_diff", 0, 32'hDEADBEEF, 32'd10, 1'b1, 1'b0);

    // Both ports on one register
    a_rr1 = 2'd3; a_rr2 = 2'd3;
    expect_out("same_addr", 0, 32'd15, 32'd15, 1'b0, 1'b0);

    // Same-cycle write visibility
    a_write(2'd0, 32'd5);
    a_we = 1'b1; a_wr = 2'd0; a_wd = 32'd42;
    a_rr1 = 2'd0; a_rr2 = 2'd1;
    expect_out("bypass", 0, BYP ? 32'd42 : 32'd5, 32'hDEADBEEF, 1'b0, 1'b1);
    tick();
    a_we = 1'b0;
    expect_out("post_bypass", 0, 32'd42, 32'hDEADBEEF, 1'b0, 1'b1);

    a_we = 1'b1; a_wr = 2'd3; a_wd = 32'd77;
    a_rv = 1'b1; a_rvr = 2'd3;
    a_rr1 = 2'd3; a_rr2 = 2'd0;
    expect_out("bypass_resv", 0, BYP ? 32'd77 : 32'd15, 32'd42, BYP, 1'b0);
    tick();
    a_we = 1'b0; a_rv = 1'b0;
    expect_out("resv_write_same", 0, 32'd77, 32'd42, 1'b1, 1'b0);

    // Unknown addresses/data with enables low leave state untouched
    a_write(2'd3, 32'd15);
    a_wr = 2'bxx; a_wd = 32'hxxxxxxxx; a_rvr = 2'bxx;
    tick();
    a_wr = 2'd0; a_wd = 32'd0; a_rvr = 2'd0;
    a_rr1 = 2'd3; a_rr2 = 2'd0;
    expect_out("x_ignored", 0, 32'd15, 32'd42, 1'b0, 1'b0);

    // Asynchronous reset mid-run
    a_rr1 = 2'd1; a_rr2 = 2'd3;
    expect_out("pre_reset", 0, 32'hDEADBEEF, 32'd15, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 0, 32'd0, 32'd0, 1'b0, 1'b0);
    a_we = 1'b1; a_wr = 2'd1; a_wd = 32'h55;
    a_rv = 1'b1; a_rvr = 2'd1;
    tick();
    expect_out("reset_ignores", 0, 32'd0, 32'd0, 1'b0, 1'b0);
    a_rv = 1'b0;
    rst_n = 1'b1;
    tick();
    a_we = 1'b0;
    expect_out("first_edge_write", 0, 32'h55, 32'd0, 1'b0, 1'b0);

    // Zero-register build
    b_we = 1'b1; b_wr = 4'd0; b_wd = 8'hFF;
    b_rv = 1'b1; b_rvr = 4'd0;
    b_rr1 = 4'd0; b_rr2 = 4'd15;
    expect_out("zr_no_bypass", 1, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    b_we = 1'b0; b_rv = 1'b0;
    expect_out("zr_r0", 1, 32'd0, 32'd0, 1'b0, 1'b0);
    b_we = 1'b1; b_wr = 4'd15; b_wd = 8'hFF;
    tick();
    b_we = 1'b0;
    expect_out("zr_r15", 1, 32'd0, 32'hFF, 1'b0, 1'b0);
    b_rv = 1'b1; b_rvr = 4'd15;
    tick();
    b_rv = 1'b0;
    b_rr1 = 4'd15; b_rr2 = 4'd0;
    expect_out("zr_resv15", 1, 32'hFF, 32'd0, 1'b1, 1'b0);

    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per register, 1..64.
REQ-002 SHALL have parameter DEPTH, default 4: register count, a power of two, 2..32; AW = log2(DEPTH).
REQ-003 SHALL have parameter ZERO_REG, default 0: when 1, register 0 is hardwired to zero.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports readReg1 and readReg2, input, AW each: read addresses.
REQ-007 SHALL have ports readData1 and readData2, output, WIDTH each: read data.
REQ-008 SHALL have ports readBusy1 and readBusy2, output, 1 each: pending flag of the addressed register.
REQ-009 SHALL have ports writeReg (input, AW), writeData (input, WIDTH) and regWrite (input, 1): write address, write data and write enable.
REQ-010 SHALL have ports resv (input, 1) and resvReg (input, AW): reserve-request strobe and reserve address.

Function
REQ-011 SHALL implement DEPTH registers of WIDTH bits plus DEPTH pending bits; registers use a plain clock, with no gated clocks.
REQ-012 SHALL write writeData into register writeReg on the rising edge when regWrite=1; all other registers hold.
REQ-013 SHALL drive readDataN combinationally from register readRegN (zero latency); both ports may address the same register.
REQ-014 SHALL set pending[resvReg] on the rising edge when resv=1.
REQ-015 SHALL clear pending[writeReg] on the rising edge when regWrite=1.
REQ-016 SHALL leave pending set when resv=1 and regWrite=1 target the same register on the same edge: reserve wins, data is still written.
REQ-017 SHALL allow resv and regWrite to different registers on the same edge, with both effects applied.
REQ-018 SHALL drive readBusyN = pending[readRegN] combinationally.
REQ-019 SHALL, when ZERO_REG=1, ignore writes and reserves to register 0, return 0 on readDataN, and return 0 on readBusyN for that address.
REQ-020 SHALL ignore writeData, writeReg, resvReg and readReg contents when the related enable is 0; X on an unused address SHALL NOT corrupt state.

Reset
REQ-021 SHALL clear all registers and all pending bits immediately when reset=0, independent of clock.
REQ-022 SHALL hold readData1 and readData2 at 0 and readBusy1 and readBusy2 at 0 while reset=0.
REQ-023 SHALL ignore regWrite and resv while reset=0.
REQ-024 SHALL perform the first write or reserve on the first rising edge after reset deasserts; a write coincident with an assertion mid-operation is lost.

Configuration
REQ-025 SHALL, with macro REGFILE_BYPASS_EN defined, return writeData on readDataN when regWrite=1 and readRegN==writeReg in the same cycle, and return readBusyN=0 unless resv to that register is also asserted (write-through forwarding, combinational path).
REQ-026 SHALL, without REGFILE_BYPASS_EN, return the pre-edge register contents and pending flag on readDataN and readBusyN during a same-cycle write.
REQ-027 SHALL leave all other behaviour identical in both builds; with ZERO_REG=1, register 0 is never bypassed.

Verification
REQ-028 Reset: drive reset=0 mid-run after writing 32'd15 to register 3 -> readData2 (readReg2=3) reads 0 asynchronously, before the next clock edge; all busy flags read 0.
REQ-029 Write/read: after reset release, write 32'd15 to register 3 and 32'hDEADBEEF to register 1 -> readReg1=1, readReg2=3 give DEADBEEF and 15 one edge after each write.
REQ-030 Scoreboard: resv on register 2 -> readBusy1=1 at readReg1=2 after the edge; a later write of 32'd7 to register 2 -> busy 0, data 7.
REQ-031 Collision: resv and regWrite both to register 2 on one edge with data 32'd9 -> busy 1, data 9; resv to 1 plus write to 2 on one edge -> busy[1]=1, busy[2]=0.
REQ-032 Bypass: regWrite=1, writeReg=0 (ZERO_REG=0), writeData=32'd42, readReg1=0 before the edge -> readData1=42 with REGFILE_BYPASS_EN, old value without it.
REQ-033 Params: WIDTH=8, DEPTH=16, ZERO_REG=1 -> write 8'hFF to register 0 then read it -> 0; write to register 15 -> reads 8'hFF.
